// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Three-requester arbiter/sequencer in front of a single-port
//            memory controller (fixed-priority / round-robin, starvation cap).
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      mode,
    input  logic [2:0]      req_valid,
    output logic [2:0]      req_ready,
    input  logic [2:0]      req_we,
    input  logic [3*AW-1:0] req_addr,
    input  logic [3*DW-1:0] req_wdata,
    output logic [2:0]      rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic [1:0]      grant_id,
    output logic            busy
);

    localparam logic [1:0] c_idle         = 2'd0;
    localparam logic [1:0] c_issue        = 2'd1;
    localparam logic [1:0] c_resp         = 2'd2;
    localparam logic [7:0] c_starve_limit = 8'(STARVE_LIMIT);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [1:0]    r_rr_ptr;
    logic [1:0]    r_grant_id;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rsp_rdata;
    logic [7:0]    r_wait [3];

    logic [2:0]    w_starved;
    logic          w_win_valid;
    logic [1:0]    w_win_id;
    logic [1:0]    w_cand;
    logic          w_accept;

    function automatic logic [1:0] f_fixed_prio(input logic [1:0] m, input logic [1:0] rank);
        logic [1:0] id;
        case (m)
            2'b01:   id = (rank == 2'd0) ? 2'd1 : ((rank == 2'd1) ? 2'd0 : 2'd2);
            2'b10:   id = 2'd2 - rank;
            default: id = rank;
        endcase
        return id;
    endfunction

    function automatic logic [1:0] f_rr_index(input logic [1:0] ptr, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_starve
            assign w_starved[gi] = req_valid[gi] && (r_wait[gi] == c_starve_limit);
        end
    endgenerate

    // Scan from lowest to highest rank; the last hit is the highest-ranked winner.
    always_comb begin : arbitrate
        w_win_valid = 1'b0;
        w_win_id    = 2'd0;
        w_cand      = 2'd0;
        if (|w_starved) begin
            for (int k = 2; k >= 0; k--) begin
                if (w_starved[k]) begin
                    w_win_valid = 1'b1;
                    w_win_id    = 2'(k);
                end
            end
        end else begin
            for (int k = 2; k >= 0; k--) begin
                w_cand = (mode == 2'b11) ? f_rr_index(r_rr_ptr, 2'(k)) : f_fixed_prio(mode, 2'(k));
                if (req_valid[w_cand]) begin
                    w_win_valid = 1'b1;
                    w_win_id    = w_cand;
                end
            end
        end
    end

    always_comb begin : fsm_next
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_win_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_issue;
                end
            end
            c_issue: begin
                if (mem_ack) begin
                    w_state_nxt = c_resp;
                end
            end
            c_resp:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : fsm_state
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : datapath
        if (!rst_n) begin
            r_rr_ptr    <= 2'd0;
            r_grant_id  <= 2'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_grant_id <= w_win_id;
                r_we       <= req_we[w_win_id];
                r_addr     <= req_addr[w_win_id*AW +: AW];
                r_wdata    <= req_wdata[w_win_id*DW +: DW];
                r_rr_ptr   <= (w_win_id == 2'd2) ? 2'd0 : w_win_id + 2'd1;
            end
            if ((r_state == c_issue) && mem_ack) begin
                r_rsp_rdata <= r_we ? '0 : mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : wait_counters
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_wait[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (req_valid[i] && !req_ready[i]) begin
                    if (r_wait[i] < c_starve_limit) begin
                        r_wait[i] <= r_wait[i] + 8'd1;
                    end
                end else begin
                    r_wait[i] <= 8'd0;
                end
            end
        end
    end

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign req_ready = (w_accept && rst_n) ? (3'b001 << w_win_id) : 3'b000;
    assign rsp_valid = (r_state == c_resp) ? (3'b001 << r_grant_id) : 3'b000;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_req   = (r_state == c_issue);
    assign mem_we    = (r_state == c_issue) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state != c_idle);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter/sequencer placed in front of the single-port UltraRAM memory controller, sharing it between three requesters (PCIe=0, softcore=1, ML accelerator=2). Accepts one request at a time over valid/ready, issues it on the memory port with a req/ack handshake, and returns a one-cycle response to the originating requester. Supports three fixed-priority modes and a round-robin mode, with starvation override.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 16, wait cycles after which a pending requester is force-granted (range 1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  00 fixed PCIe>core>ML; 01 core>PCIe>ML; 10 ML>core>PCIe; 11 round-robin
- req_valid  in  3  request valid, bit i = requester i
- req_ready  out  3  request accepted, one-hot or zero
- req_we  in  3  1=write, 0=read, per requester
- req_addr  in  3*AW  addresses, requester i at [i*AW +: AW]
- req_wdata  in  3*DW  write data, requester i at [i*DW +: DW]
- rsp_valid  out  3  response pulse, one-hot or zero
- rsp_rdata  out  DW  read data for the responding requester
- mem_req  out  1  memory port request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  memory completion, may be same cycle as mem_req
- mem_rdata  in  DW  read data, valid in mem_ack cycle
- grant_id  out  2  requester of the transaction in flight
- busy  out  1  high when state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP. Only one transaction outstanding.
- IDLE: if any req_valid, select a winner combinationally and assert req_ready[winner]. Capture addr/wdata/we/id into registers. Go to ISSUE. Otherwise stay.
- ISSUE: drive mem_req=1 with captured fields. Hold them stable until mem_ack. On mem_ack, capture mem_rdata for reads; for writes, capture 0. Go to RESP.
- RESP: rsp_valid[grant_id]=1 for exactly one cycle with rsp_rdata. Go to IDLE.
- Selection order:
  - First, starvation override. If any wait_cnt[i]==STARVE_LIMIT, the lowest such index wins.
  - Else in modes 00/01/10, use the fixed order.
  - Else in mode 11, search starts at rr_ptr and takes the first valid requester cyclically (rr_ptr, rr_ptr+1, ... mod 3).
- rr_ptr resets to 0. On every grant it becomes (winner+1) mod 3, in any mode.
- mode 11 encoding is round-robin. mode is sampled only during IDLE arbitration; changes mid-transaction have no effect.
- wait_cnt[i] (8-bit, saturating at STARVE_LIMIT):
  - increments each cycle req_valid[i]=1 and req_ready[i]=0;
  - clears when req_ready[i]=1 or req_valid[i]=0.
- Requesters hold valid and payload until ready. The arbiter does not check this.
- rsp_rdata holds its last value outside RESP.

## Timing
- Reset (async assert, sync deassert expected): state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, grant_id=0, busy=0, rr_ptr=0, all wait_cnt=0.
- req_ready is forced 0 while rst_n is low.
- Reset mid-transaction drops mem_req immediately. The transaction is lost and no response is given.
- Accept at cycle T. mem_req rises at T+1. If mem_ack arrives at T+1+k (k≥0), rsp_valid fires at T+2+k. Minimum latency is 2 cycles; peak throughput is one transaction per 3 cycles.
- req_ready is only ever asserted in IDLE. New requests arriving during ISSUE/RESP wait, and their wait_cnt advances.
- mem_ack outside ISSUE is ignored.
- busy = (state != IDLE), registered with state.

## Test plan
- Mode 00, all three valid at cycle 0, mem_ack tied 1: grants occur in order 0,1,2. The ready pulses are 3 cycles apart, and each rsp_valid comes 2 cycles after its ready.
- Mode 11, all valid continuously: grants cycle 0,1,2,0,1,2. rr_ptr is 1,2,0 after successive grants.
- Mode 10, requester 2 always valid, requester 0 valid with STARVE_LIMIT=4: requester 0 is granted at its first IDLE arbitration after wait_cnt[0] reaches 4.
- Read addr 0x40 from requester 1 with mem_ack delayed 5 cycles and mem_rdata=0xDEADBEEF: mem_req stays high for 6 cycles with mem_addr=0x40. rsp_valid=3'b010 and rsp_rdata=0xDEADBEEF the cycle after ack.
- Write from requester 0 (addr 0x80, data 0x12345678): mem_we=1 with matching fields; the response has rsp_rdata=0.
- Assert rst_n=0 during ISSUE: mem_req and busy go to 0 asynchronously. No rsp_valid follows, and the first grant after release follows rr_ptr=0.
